// File: rtl/stack_pointer_unit.sv
// Down-growing stack pointer with load/pop/push/adjust, depth/empty/full decode.
// Bounds checking, sticky overflow/underflow flags and trap pulse are built only with STACK_GUARD_EN.
module stack_pointer_unit #(
  parameter int unsigned  W     = 16,
  parameter logic [W-1:0] TOP   = 16'hFFFF,
  parameter logic [W-1:0] LIMIT = 16'hFF00,
  parameter int unsigned  OFF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       sel,
  input  logic [W-1:0]     in,
  input  logic [OFF_W-1:0] offset,
  input  logic             err_clr,
  output logic [W-1:0]     out,
  output logic [W-1:0]     depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             trap
);

  localparam int unsigned CW = W + 2;
  localparam logic signed [CW-1:0] ONE = CW'(1);

  logic signed [CW-1:0] cur;
  logic signed [CW-1:0] cand;
  logic [W-1:0]         nxt_out;

  // Candidate in W+2-bit signed arithmetic so carries and borrows stay visible
  always_comb begin
    cur = $signed({2'b00, out});
    case (sel)
      2'b00:   cand = $signed({2'b00, in});
      2'b01:   cand = cur + ONE;
      2'b10:   cand = cur - ONE;
      default: cand = cur + CW'($signed(offset));
    endcase
  end

  assign depth = TOP - out;
  assign empty = (out == TOP);
  assign full  = (out == LIMIT);

`ifdef STACK_GUARD_EN
  logic nxt_ovf;
  logic nxt_unf;
  logic nxt_trap;
  logic ovf_r;
  logic unf_r;
  logic trap_r;
  logic below;
  logic above;

  assign below = (cand < $signed({2'b00, LIMIT}));
  assign above = (cand > $signed({2'b00, TOP}));

  // Clear happens first so a same-cycle error leaves its flag set
  always_comb begin
    nxt_out  = out;
    nxt_ovf  = ovf_r;
    nxt_unf  = unf_r;
    nxt_trap = 1'b0;
    if (err_clr) begin
      nxt_ovf = 1'b0;
      nxt_unf = 1'b0;
    end
    if (enable) begin
      if (below) begin
        nxt_ovf  = 1'b1;
        nxt_trap = 1'b1;
      end else if (above) begin
        nxt_unf  = 1'b1;
        nxt_trap = 1'b1;
      end else begin
        nxt_out = cand[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= TOP;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
      trap_r <= 1'b0;
    end else begin
      out    <= nxt_out;
      ovf_r  <= nxt_ovf;
      unf_r  <= nxt_unf;
      trap_r <= nxt_trap;
    end
  end

  assign overflow  = ovf_r;
  assign underflow = unf_r;
  assign trap      = trap_r;
`else
  logic [2:0] unused_bits;

  // Unchecked build: every op wraps modulo 2^W
  always_comb begin
    nxt_out = out;
    if (enable) begin
      nxt_out = cand[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= TOP;
    end else begin
      out <= nxt_out;
    end
  end

  assign unused_bits = {err_clr, cand[CW-1:W]};
  assign overflow    = 1'b0;
  assign underflow   = 1'b0;
  assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit; expectations follow STACK_GUARD_EN of the build.
module tb_stack_pointer_unit;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  sel;
  logic [15:0] in_v;
  logic [7:0]  offset;
  logic        err_clr;
  logic [15:0] out;
  logic [15:0] depth;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
  logic        trap;

  int total;
  int bad;

  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] POP = 2'b01;
  localparam logic [1:0] PSH = 2'b10;
  localparam logic [1:0] ADJ = 2'b11;

  stack_pointer_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .sel(sel), .in(in_v), .offset(offset),
    .err_clr(err_clr), .out(out), .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic en, input logic [1:0] s,
                      input logic [15:0] v, input logic [7:0] off, input logic clr);
    @(negedge clk);
    rst = r; enable = en; sel = s; in_v = v; offset = off; err_clr = clr;
    @(posedge clk);
    #1;
    rst = 1'b0; enable = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [15:0] o, input logic ov,
                        input logic un, input logic tr);
    chk({tag, ".out"}, out, o);
    chk({tag, ".ovf"}, 16'(overflow), 16'(ov));
    chk({tag, ".unf"}, 16'(underflow), 16'(un));
    chk({tag, ".trap"}, 16'(trap), 16'(tr));
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; enable = 1'b0; sel = LD; in_v = '0; offset = '0; err_clr = 1'b0;

    step(1, 0, LD, 16'h0, 8'h0, 0);
    chk_st("reset", 16'hFFFF, 0, 0, 0);
    chk("reset.depth", depth, 16'h0000);
    chk("reset.empty", 16'(empty), 16'h1);
    chk("reset.full", 16'(full), 16'h0);

    step(0, 1, PSH, 16'h0, 8'h0, 0);
    step(0, 1, PSH, 16'h0, 8'h0, 0);
    step(0, 1, PSH, 16'h0, 8'h0, 0);
    chk_st("push3", 16'hFFFC, 0, 0, 0);
    chk("push3.depth", depth, 16'h0003);
    chk("push3.empty", 16'(empty), 16'h0);
    step(0, 1, POP, 16'h0, 8'h0, 0);
    step(0, 1, POP, 16'h0, 8'h0, 0);
    chk("pop2", out, 16'hFFFE);
    step(0, 1, ADJ, 16'h0, 8'hFE, 0);
    chk("adj_m2", out, 16'hFFFC);
    step(0, 0, PSH, 16'h0, 8'h0, 0);
    chk("hold", out, 16'hFFFC);

`ifdef STACK_GUARD_EN
    step(0, 1, LD, 16'hFF00, 8'h0, 0);
    chk_st("ld_limit", 16'hFF00, 0, 0, 0);
    chk("ld_limit.full", 16'(full), 16'h1);
    step(0, 1, PSH, 16'h0, 8'h0, 0);
    chk_st("push_full", 16'hFF00, 1, 0, 1);
    chk("push_full.full", 16'(full), 16'h1);
    step(0, 0, PSH, 16'h0, 8'h0, 0);
    chk_st("after_trap", 16'hFF00, 1, 0, 0);
    step(0, 0, LD, 16'h0, 8'h0, 1);
    chk_st("clr_ovf", 16'hFF00, 0, 0, 0);

    step(0, 1, LD, 16'hFFFF, 8'h0, 0);
    chk("ld_top.empty", 16'(empty), 16'h1);
    step(0, 1, POP, 16'h0, 8'h0, 0);
    chk_st("pop_empty", 16'hFFFF, 0, 1, 1);
    step(0, 1, POP, 16'h0, 8'h0, 1);
    chk_st("clr_vs_err", 16'hFFFF, 0, 1, 1);
    step(0, 0, POP, 16'h0, 8'h0, 1);
    chk_st("clr_unf", 16'hFFFF, 0, 0, 0);

    step(0, 1, LD, 16'h0010, 8'h0, 0);
    chk_st("ld_low", 16'hFFFF, 1, 0, 1);
    step(0, 1, POP, 16'h0, 8'h0, 1);
    chk_st("clr_ovf_new_unf", 16'hFFFF, 0, 1, 1);
    step(0, 0, LD, 16'h0, 8'h0, 1);
    step(0, 1, LD, 16'hFFF0, 8'h0, 0);
    chk_st("ld_fff0", 16'hFFF0, 0, 0, 0);
    step(0, 1, ADJ, 16'h0, 8'h7F, 0);
    chk_st("adj_over_top", 16'hFFF0, 0, 1, 1);
    step(0, 1, ADJ, 16'h0, 8'h00, 0);
    chk_st("adj_zero", 16'hFFF0, 0, 1, 0);
    step(0, 1, ADJ, 16'h0, 8'h80, 0);
    chk_st("adj_m128", 16'hFF70, 0, 1, 0);
    chk("adj_m128.depth", depth, 16'h008F);
    step(1, 1, PSH, 16'h0, 8'h0, 1);
    chk_st("rst_vs_push", 16'hFFFF, 0, 0, 0);
`else
    step(0, 1, LD, 16'h0000, 8'h0, 0);
    chk("ld_zero", out, 16'h0000);
    step(0, 1, PSH, 16'h0, 8'h0, 1);
    chk_st("push_wrap", 16'hFFFF, 0, 0, 0);
    chk("push_wrap.empty", 16'(empty), 16'h1);
    step(0, 1, POP, 16'h0, 8'h0, 0);
    chk_st("pop_wrap", 16'h0000, 0, 0, 0);
    chk("pop_wrap.depth", depth, 16'hFFFF);
    step(0, 1, LD, 16'hFF00, 8'h0, 0);
    chk("ld_limit.full", 16'(full), 16'h1);
    step(0, 1, PSH, 16'h0, 8'h0, 0);
    chk_st("push_below", 16'hFEFF, 0, 0, 0);
    chk("push_below.full", 16'(full), 16'h0);
    chk("push_below.depth", depth, 16'h0100);
    step(0, 1, ADJ, 16'h0, 8'h7F, 0);
    chk("adj_p127", out, 16'hFF7E);
    step(0, 1, PSH, 16'h0, 8'h0, 0);
    step(1, 1, PSH, 16'h0, 8'h0, 0);
    chk_st("rst_vs_push", 16'hFFFF, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
